hc_multi: RTL and testbench

//   N-channel hysteresis winner tracker. Generalises the two-channel timestamp

---
 rtl/hc_multi.sv | 129 ++++++++++++
 tb/tb_hc_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hc_multi.sv
// N-channel hysteresis winner tracker: stage 1 registers the sample, stage 2 picks
// the arg-max channel and switches the winner only past a threshold margin and dwell lockout.
module hc_multi_lane #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDX   = 0
) (
    input  logic [N-1:0][WIDTH-1:0] vals_i,
    output logic                    is_max_o
);
    // Lane wins when it strictly beats every lower lane and is not beaten by any higher one,
    // so exactly one lane is flagged and ties resolve to the lowest index.
    always_comb begin
        is_max_o = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (j < IDX && !(vals_i[IDX] > vals_i[j])) is_max_o = 1'b0;
            if (j > IDX && (vals_i[j] > vals_i[IDX]))  is_max_o = 1'b0;
        end
    end
endmodule

module hc_multi #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int DWELL   = 0,
    parameter int RST_IDX = 1,
    localparam int IDXW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [N*WIDTH-1:0] ts,
    input  logic [WIDTH-1:0]   th,
    output logic [IDXW-1:0]    win_idx,
    output logic [N-1:0]       win_onehot,
    output logic               sw_pulse,
    output logic               out_valid
);
    localparam int HW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    logic                    s1_v_q;
    logic [N-1:0][WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]        th_q;

    logic [IDXW-1:0] win_idx_q, win_idx_d;
    logic [N-1:0]    win_oh_q, win_oh_d;
    logic            sw_q, sw_d;
    logic            ov_q;
    logic [HW-1:0]   hold_q, hold_d;

    logic [N-1:0]     cand_oh;
    logic [IDXW-1:0]  cand;
    logic [WIDTH-1:0] cand_val, cur_val;
    logic             do_sw;

    // Stage 1: sample capture; data needs no reset since s1_v_q gates its use
    always_ff @(posedge clk) begin
        if (!rst) s1_v_q <= 1'b0;
        else      s1_v_q <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            ts_q <= ts;
            th_q <= th;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        hc_multi_lane #(.N(N), .WIDTH(WIDTH), .IDX(g)) u_lane (
            .vals_i   (ts_q),
            .is_max_o (cand_oh[g])
        );
    end

    always_comb begin
        cand     = '0;
        cand_val = '0;
        cur_val  = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_oh[i]) begin
                cand     = cand | IDXW'(i);
                cand_val = cand_val | ts_q[i];
            end
            if (win_idx_q == IDXW'(i)) cur_val = ts_q[i];
        end
    end

    // Margin compare is done one bit wider so cur + th can never wrap
    assign do_sw = s1_v_q && (cand != win_idx_q) && (hold_q == '0) &&
                   ({1'b0, cand_val} > ({1'b0, cur_val} + {1'b0, th_q}));

    always_comb begin
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        sw_d      = 1'b0;
        hold_d    = hold_q;
        if (do_sw) begin
            win_idx_d = cand;
            win_oh_d  = N'(1) << cand;
            sw_d      = 1'b1;
            hold_d    = HW'(DWELL);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
    end

    // Stage 2: decision registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_idx_q <= IDXW'(RST_IDX);
            win_oh_q  <= N'(1) << RST_IDX;
            sw_q      <= 1'b0;
            ov_q      <= 1'b0;
            hold_q    <= '0;
        end else begin
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            sw_q      <= sw_d;
            ov_q      <= s1_v_q;
            hold_q    <= hold_d;
        end
    end

    assign win_idx    = win_idx_q;
    assign win_onehot = win_oh_q;
    assign sw_pulse   = sw_q;
    assign out_valid  = ov_q;
endmodule

// File: tb/tb_hc_multi.sv
// Bench for hc_multi: a DWELL=0 and a DWELL=3 instance share stimulus; expected
// decisions are queued at drive time and popped when out_valid appears.
module tb_hc_multi;
    typedef struct {
        logic [31:0] ts;
        logic [7:0]  th;
        logic        gap;
        int          idx;
        logic        sw;
    } vec_t;

    typedef struct {
        int   idx;
        logic sw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] ts = '0;
    logic [7:0]  th = '0;

    logic [1:0] idx0, idx3;
    logic [3:0] oh0, oh3;
    logic       sw0, sw3, ov0, ov3;

    exp_t q0[$];
    exp_t q3[$];
    bit   chk3 = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl[14];

    always #5 clk = ~clk;

    hc_multi #(.N(4), .WIDTH(8), .DWELL(0), .RST_IDX(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ts(ts), .th(th),
        .win_idx(idx0), .win_onehot(oh0), .sw_pulse(sw0), .out_valid(ov0)
    );

    hc_multi #(.N(4), .WIDTH(8), .DWELL(3), .RST_IDX(1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ts(ts), .th(th),
        .win_idx(idx3), .win_onehot(oh3), .sw_pulse(sw3), .out_valid(ov3)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov0) begin
            if (q0.size() == 0) chk("dut0 unexpected out_valid", 1, 0);
            else begin
                e = q0.pop_front();
                chk("dut0 win_idx", int'(idx0), e.idx);
                chk("dut0 win_onehot", int'(oh0), 1 << e.idx);
                chk("dut0 sw_pulse", int'(sw0), int'(e.sw));
            end
        end else begin
            chk("dut0 idle sw_pulse", int'(sw0), 0);
        end
        if (chk3) begin
            if (ov3) begin
                if (q3.size() == 0) chk("dut3 unexpected out_valid", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("dut3 win_idx", int'(idx3), e.idx);
                    chk("dut3 win_onehot", int'(oh3), 1 << e.idx);
                    chk("dut3 sw_pulse", int'(sw3), int'(e.sw));
                end
            end else begin
                chk("dut3 idle sw_pulse", int'(sw3), 0);
            end
        end
    end

    task automatic drive(input logic [31:0] t, input logic [7:0] h,
                         input int e0, input logic s0, input int e3, input logic s3);
        exp_t x;
        ts = t; th = h; in_valid = 1'b1;
        x.idx = e0; x.sw = s0; q0.push_back(x);
        if (chk3) begin
            x.idx = e3; x.sw = s3; q3.push_back(x);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, " dut0 win_idx"}, int'(idx0), 1);
        chk({tag, " dut0 win_onehot"}, int'(oh0), 2);
        chk({tag, " dut0 sw_pulse"}, int'(sw0), 0);
        chk({tag, " dut0 out_valid"}, int'(ov0), 0);
        chk({tag, " dut3 win_idx"}, int'(idx3), 1);
        chk({tag, " dut3 win_onehot"}, int'(oh3), 2);
        chk({tag, " dut3 sw_pulse"}, int'(sw3), 0);
        chk({tag, " dut3 out_valid"}, int'(ov3), 0);
    endtask

    // Two reset edges; anything in flight at the first one is discarded by the DUT
    task automatic do_reset(input bit check_first);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        q0.delete(); q3.delete();
        if (check_first) chk_rst_vals("reset-edge");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    localparam logic [31:0] A = 32'h0000_0064;
    localparam logic [31:0] B = 32'h0000_6400;

    initial begin
        tbl[0]  = '{32'h0000_646E, 8'd10,  1'b0, 1, 1'b0};
        tbl[1]  = '{32'h0000_646F, 8'd10,  1'b0, 0, 1'b1};
        tbl[2]  = '{32'h0000_FFFA, 8'd10,  1'b0, 0, 1'b0};
        tbl[3]  = '{32'h0000_0505, 8'd0,   1'b0, 0, 1'b0};
        tbl[4]  = '{32'h0000_0605, 8'd0,   1'b0, 1, 1'b1};
        tbl[5]  = '{32'h0000_FAFF, 8'd10,  1'b1, 1, 1'b0};
        tbl[6]  = '{32'h0000_05FA, 8'd10,  1'b0, 0, 1'b1};
        tbl[7]  = '{32'h0000_C800, 8'd0,   1'b0, 1, 1'b1};
        tbl[8]  = '{32'hC8C8_0000, 8'd10,  1'b0, 2, 1'b1};
        tbl[9]  = '{32'h5032_0000, 8'd30,  1'b0, 2, 1'b0};
        tbl[10] = '{32'hFF00_0000, 8'd255, 1'b0, 2, 1'b0};
        tbl[11] = '{32'hFF00_0000, 8'd254, 1'b1, 3, 1'b1};
        tbl[12] = '{32'h0000_0000, 8'd0,   1'b0, 3, 1'b0};
        tbl[13] = '{32'h0000_0001, 8'd0,   1'b0, 0, 1'b1};

        do_reset(1'b0);
        chk_rst_vals("after-release");

        // Two-edge latency: nothing after the first edge, decision after the second
        drive(32'h0000_0900, 8'd0, 1, 1'b0, 1, 1'b0);
        chk("latency edge1 out_valid", int'(ov0), 0);
        @(posedge clk); #1;
        chk("latency edge2 out_valid", int'(ov0), 1);
        idle(3);

        chk3 = 1'b0;
        foreach (tbl[i]) begin
            if (tbl[i].gap) idle(1);
            drive(tbl[i].ts, tbl[i].th, tbl[i].idx, tbl[i].sw, 0, 1'b0);
        end
        idle(3);

        // Dwell: DWELL=3 holds until the fourth following decision, DWELL=0 switches back-to-back
        do_reset(1'b0);
        chk3 = 1'b1;
        drive(A, 8'd10, 0, 1'b1, 0, 1'b1);
        drive(B, 8'd10, 1, 1'b1, 0, 1'b0);
        drive(B, 8'd10, 1, 1'b0, 0, 1'b0);
        drive(B, 8'd10, 1, 1'b0, 0, 1'b0);
        drive(B, 8'd10, 1, 1'b0, 1, 1'b1);
        drive(A, 8'd10, 0, 1'b1, 1, 1'b0);
        idle(3);

        // Reset with hold_cnt=2 in dut3 and a sample sitting in stage 1
        do_reset(1'b0);
        drive(A, 8'd10, 0, 1'b1, 0, 1'b1);
        drive(B, 8'd10, 1, 1'b1, 0, 1'b0);
        drive(B, 8'd10, 1, 1'b0, 0, 1'b0);
        do_reset(1'b1);
        idle(3);
        chk("dut0 post-reset win_idx", int'(idx0), 1);
        chk("dut3 post-reset win_idx", int'(idx3), 1);

        chk("dut0 scoreboard drained", q0.size(), 0);
        chk("dut3 scoreboard drained", q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
